fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 50 +++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch front end: widths, the fetched-pair
// record and a PC alignment helper.
package fetch_unit_pkg;
    localparam int INSTR_W     = 32;
    localparam int ROM_ADDR_W  = 10;
    localparam int FETCH_WIDTH = 2;
    localparam int PC_W        = 32;
    localparam int BUF_DEPTH   = 2;

    typedef struct packed {
        logic [PC_W-1:0]    pc1;
        logic [PC_W-1:0]    pc2;
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
    } pair_t;

    localparam int PAIR_W = $bits(pair_t);

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instruction pairs; flush empties it in one cycle.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [PAIR_W-1:0] push_data,
    output logic [PAIR_W-1:0] head,
    output logic [1:0]        count
);
    logic [1:0]        count_reg;
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic [PAIR_W-1:0] entry_reg [BUF_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (push && !flush && wr_ptr_reg == 1'(gi)) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (flush) begin
            count_reg  <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = entry_reg[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: reads two consecutive ROM words per cycle and
// hands them to decode as a pair through a small elastic buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ROM_ADDR_W-1:0] rom_addr1,
    output logic [ROM_ADDR_W-1:0] rom_addr2,
    input  logic [INSTR_W-1:0]    rom_instr1,
    input  logic [INSTR_W-1:0]    rom_instr2,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc1,
    output logic [PC_W-1:0]       out_pc2,
    output logic [INSTR_W-1:0]    out_instr1,
    output logic [INSTR_W-1:0]    out_instr2
);
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] req_pc_reg;
    logic            inflight_reg;

    logic [1:0]      count;
    logic [2:0]      occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    pair_t           push_pair;
    pair_t           head_pair;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = inflight_reg && !redirect_valid;

    // A pair leaving this cycle frees its slot in time for a new fetch,
    // which is what sustains one pair per cycle.
    assign occupancy = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue     = !redirect_valid && (occupancy < 3'd2);

    assign rom_addr1 = pc_reg[ROM_ADDR_W+1:2];
    assign rom_addr2 = pc_reg[ROM_ADDR_W+1:2] + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            inflight_reg <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= align_pc(redirect_pc);
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg     <= pc_reg + 32'd8;
                req_pc_reg <= pc_reg;
            end
        end
    end

    always_comb begin
        push_pair        = '0;
        push_pair.pc1    = req_pc_reg;
        push_pair.pc2    = req_pc_reg + 32'd4;
        push_pair.instr1 = rom_instr1;
        push_pair.instr2 = rom_instr2;
    end

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_pair),
        .head      (head_pair),
        .count     (count)
    );

    assign out_pc1    = head_pair.pc1;
    assign out_pc2    = head_pair.pc2;
    assign out_instr1 = head_pair.instr1;
    assign out_instr2 = head_pair.instr2;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous ROM model, directed scenarios with literal
// expectations, then randomized ready/redirect/reset against a pair-stream model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rom_addr1, rom_addr2;
    logic [31:0] rom_instr1 = '0, rom_instr2 = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc1, out_pc2, out_instr1, out_instr2;

    int checks = 0;
    int errors = 0;

    // Model: exp_pc is the next pair pc decode must receive; age counts cycles
    // since reset release or redirect (pairs appear from age 2 on and then never
    // run dry); the fetch pointer runs min(age,2) pairs ahead of delivery.
    int          age = 0;
    logic [31:0] exp_pc = 32'h0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr1      (rom_addr1),
        .rom_addr2      (rom_addr2),
        .rom_instr1     (rom_instr1),
        .rom_instr2     (rom_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc1        (out_pc1),
        .out_pc2        (out_pc2),
        .out_instr1     (out_instr1),
        .out_instr2     (out_instr2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    always @(posedge clk) begin
        rom_instr1 <= rom_word(rom_addr1);
        rom_instr2 <= rom_word(rom_addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] fetch_pc;
        logic [9:0]  word;
        if (rst) begin
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_pc1", out_pc1, 32'd0);
            chk("rst_instr2", out_instr2, 32'd0);
            age    = 0;
            exp_pc = 32'h0;
        end else begin
            fetch_pc = exp_pc + 32'(8 * ((age < 2) ? age : 2));
            chk("m_addr1", {22'd0, rom_addr1}, {22'd0, fetch_pc[11:2]});
            chk("m_addr2", {22'd0, rom_addr2}, {22'd0, 10'(fetch_pc[11:2] + 10'd1)});
            chk("m_valid", {31'd0, out_valid}, (age >= 2) ? 32'd1 : 32'd0);
            if (out_valid) begin
                word = exp_pc[11:2];
                chk("m_pc1", out_pc1, exp_pc);
                chk("m_pc2", out_pc2, exp_pc + 32'd4);
                chk("m_instr1", out_instr1, rom_word(word));
                chk("m_instr2", out_instr2, rom_word(word + 10'd1));
            end
            if (redirect_valid) begin
                age    = 0;
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_valid && out_ready) exp_pc = exp_pc + 32'd8;
                if (age < 2) age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = ready;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset then streaming with decode always ready.
        do_reset(1'b1);
        chk("r_addr1_first", {22'd0, rom_addr1}, 32'd0);
        tick();
        chk("r_valid_age1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("r_pc1_a", out_pc1, 32'h0);
        chk("r_instr1_a", out_instr1, 32'h1000_0000);
        chk("r_instr2_a", out_instr2, 32'h1000_0001);
        tick();
        chk("r_pc1_b", out_pc1, 32'h8);
        chk("r_instr1_b", out_instr1, 32'h1000_0002);
        chk("r_instr2_b", out_instr2, 32'h1000_0003);
        tick();
        chk("r_pc1_c", out_pc1, 32'h10);

        // Backpressure from the first pair onward.
        do_reset(1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_pc1", out_pc1, 32'h0);
            chk("bp_fetch_held", {22'd0, rom_addr1}, 32'd4);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_rel0", out_pc1, 32'h0);
        tick();
        chk("bp_rel1", out_pc1, 32'h8);
        tick();
        chk("bp_rel2", out_pc1, 32'h10);
        tick();

        // Redirect during streaming.
        do_redirect(32'h0000_0100);
        chk("rd_flushed", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        chk("rd_pc1", out_pc1, 32'h100);
        chk("rd_instr1", out_instr1, 32'h1000_0040);
        chk("rd_instr2", out_instr2, 32'h1000_0041);
        tick();

        // Misaligned redirect target.
        do_redirect(32'h0000_0106);
        tick();
        tick();
        chk("mis_pc1", out_pc1, 32'h104);
        chk("mis_pc2", out_pc2, 32'h108);
        tick();

        // ROM address wrap.
        do_redirect(32'h0000_0FFC);
        chk("wr_addr1", {22'd0, rom_addr1}, 32'd1023);
        chk("wr_addr2", {22'd0, rom_addr2}, 32'd0);
        tick();
        tick();
        chk("wr_instr1", out_instr1, 32'h1000_03FF);
        chk("wr_instr2", out_instr2, 32'h1000_0000);
        tick();

        // Asynchronous reset with two pairs buffered.
        out_ready = 1'b0;
        repeat (4) tick();
        chk("mr_full", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mr_valid_now", {31'd0, out_valid}, 32'd0);
        chk("mr_pc1_now", out_pc1, 32'h0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mr_restart_pc1", out_pc1, 32'h0);
        chk("mr_restart_instr1", out_instr1, 32'h1000_0000);

        // Randomized ready, redirect and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            tick();
            rst            = 1'b0;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                rst            = 1'b1;
                redirect_valid = 1'b0;
            end
        end
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
